// File: rtl/i2c_xfer_seq.sv
// Round-robin I2C register-access sequencer for the byte controller.
// Turns one captured descriptor into a start/dev/reg/data/stop command stream.
module i2c_xfer_seq #(
   parameter int NREQ   = 2,
   parameter int MAXLEN = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NREQ-1:0]          req_valid_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic [NREQ-1:0]          req_rnw_i,
   input  logic [7*NREQ-1:0]        req_dev_i,
   input  logic [8*NREQ-1:0]        req_reg_i,
   input  logic [3*NREQ-1:0]        req_len_i,
   input  logic [8*MAXLEN*NREQ-1:0] req_wdata_i,
   output logic [NREQ-1:0]          rsp_valid_o,
   output logic [1:0]               rsp_err_o,
   output logic [8*MAXLEN-1:0]      rsp_rdata_o,
   output logic                     busy_o,
   output logic                     start_o,
   output logic                     stop_o,
   output logic                     read_o,
   output logic                     write_o,
   output logic                     ack_o,
   output logic [7:0]               dat_o,
   input  logic                     cmd_ack_i,
   input  logic                     ack_i,
   input  logic [7:0]               dat_i,
   input  logic                     al_i
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int DW = 8 * MAXLEN;

   // command encodings: {start, stop, read, write, ack}
   localparam logic [4:0] C_STWR = 5'b10010;
   localparam logic [4:0] C_WR   = 5'b00010;
   localparam logic [4:0] C_WRSP = 5'b01010;
   localparam logic [4:0] C_RD   = 5'b00100;
   localparam logic [4:0] C_RDSP = 5'b01101;
   localparam logic [4:0] C_SP   = 5'b01000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHK,
      S_DEV,
      S_REG,
      S_WDAT,
      S_RDEV,
      S_RDAT,
      S_STOP,
      S_RSP
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_owner;
   logic            r_rnw;
   logic [6:0]      r_dev;
   logic [7:0]      r_reg;
   logic [2:0]      r_len;
   logic [2:0]      r_k;
   logic [DW-1:0]   r_wdata;
   logic [DW-1:0]   r_rdata;
   logic [1:0]      r_err;
   logic [NREQ-1:0] r_ready;
   logic [NREQ-1:0] r_rsp;
   logic            r_busy;
   logic            r_ld;
   logic [4:0]      r_cmd;
   logic [7:0]      r_dat;

   logic            w_gnt_vld;
   logic [PW-1:0]   w_gnt;
   logic [PW-1:0]   w_ptr_nx;
   logic [NREQ-1:0] w_own1h;
   logic            w_last;
   logic            w_badlen;
   logic [7:0]      w_wbyte;
   logic [4:0]      w_cmd;
   logic [7:0]      w_dat;

   // lowest offset from the pointer wins, hence the descending scan
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid_i[(int'(r_ptr) + i) % NREQ]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = PW'((int'(r_ptr) + i) % NREQ);
         end
      end
   end

   assign w_ptr_nx = (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + PW'(1);
   assign w_own1h  = NREQ'(1) << r_owner;
   assign w_last   = (r_k == (r_len - 3'd1));
   assign w_badlen = (r_len == 3'd0) || (r_len > 3'(MAXLEN));
   assign w_wbyte  = 8'(r_wdata >> {r_k, 3'b000});

   always_comb begin
      w_cmd = 5'b00000;
      w_dat = 8'h00;
      unique case (r_state)
         S_DEV: begin
            w_cmd = C_STWR;
            w_dat = {r_dev, 1'b0};
         end
         S_REG: begin
            w_cmd = C_WR;
            w_dat = r_reg;
         end
         S_WDAT: begin
            w_cmd = w_last ? C_WRSP : C_WR;
            w_dat = w_wbyte;
         end
         S_RDEV: begin
            w_cmd = C_STWR;
            w_dat = {r_dev, 1'b1};
         end
         S_RDAT: w_cmd = w_last ? C_RDSP : C_RD;
         S_STOP: w_cmd = C_SP;
         default: begin
            w_cmd = 5'b00000;
            w_dat = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_rnw   <= 1'b0;
         r_dev   <= '0;
         r_reg   <= '0;
         r_len   <= '0;
         r_k     <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 2'b00;
         r_ready <= '0;
         r_rsp   <= '0;
         r_busy  <= 1'b0;
         r_ld    <= 1'b0;
         r_cmd   <= '0;
         r_dat   <= '0;
      end else begin
         r_ready <= '0;
         r_rsp   <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_ready <= NREQ'(1) << w_gnt;
                  r_owner <= w_gnt;
                  r_ptr   <= w_ptr_nx;
                  r_rnw   <= req_rnw_i[w_gnt];
                  r_dev   <= req_dev_i[7*w_gnt +: 7];
                  r_reg   <= req_reg_i[8*w_gnt +: 8];
                  r_len   <= req_len_i[3*w_gnt +: 3];
                  r_wdata <= req_wdata_i[DW*w_gnt +: DW];
                  r_rdata <= '0;
                  r_err   <= 2'b00;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CHK;
               end
            end
            S_CHK: begin
               if (w_badlen) begin
                  r_err   <= 2'b11;
                  r_rsp   <= w_own1h;
                  r_state <= S_RSP;
               end else begin
                  r_ld    <= 1'b1;
                  r_state <= S_DEV;
               end
            end
            S_RSP: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               if (al_i) begin
                  r_cmd   <= '0;
                  r_dat   <= '0;
                  r_ld    <= 1'b0;
                  r_err   <= 2'b10;
                  r_rsp   <= w_own1h;
                  r_state <= S_RSP;
               end else if (r_ld) begin
                  r_ld  <= 1'b0;
                  r_cmd <= w_cmd;
                  r_dat <= w_dat;
               end else if (cmd_ack_i) begin
                  r_cmd <= '0;
                  r_dat <= '0;
                  r_ld  <= 1'b1;
                  unique case (r_state)
                     S_DEV: begin
                        if (ack_i) begin
                           r_err   <= 2'b01;
                           r_state <= S_STOP;
                        end else begin
                           r_state <= S_REG;
                        end
                     end
                     S_REG: begin
                        r_k <= '0;
                        if (ack_i) begin
                           r_err   <= 2'b01;
                           r_state <= S_STOP;
                        end else if (r_rnw) begin
                           r_state <= S_RDEV;
                        end else begin
                           r_state <= S_WDAT;
                        end
                     end
                     S_WDAT: begin
                        if (ack_i) r_err <= 2'b01;
                        if (w_last) begin
                           r_ld    <= 1'b0;
                           r_rsp   <= w_own1h;
                           r_state <= S_RSP;
                        end else if (ack_i) begin
                           r_state <= S_STOP;
                        end else begin
                           r_k <= r_k + 3'd1;
                        end
                     end
                     S_RDEV: begin
                        if (ack_i) begin
                           r_err   <= 2'b01;
                           r_state <= S_STOP;
                        end else begin
                           r_state <= S_RDAT;
                        end
                     end
                     S_RDAT: begin
                        r_rdata[{r_k, 3'b000} +: 8] <= dat_i;
                        if (w_last) begin
                           r_ld    <= 1'b0;
                           r_rsp   <= w_own1h;
                           r_state <= S_RSP;
                        end else begin
                           r_k <= r_k + 3'd1;
                        end
                     end
                     S_STOP: begin
                        r_ld    <= 1'b0;
                        r_rsp   <= w_own1h;
                        r_state <= S_RSP;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   assign req_ready_o = r_ready;
   assign rsp_valid_o = r_rsp;
   assign rsp_err_o   = r_err;
   assign rsp_rdata_o = r_rdata;
   assign busy_o      = r_busy;
   assign dat_o       = r_dat;
   assign {start_o, stop_o, read_o, write_o, ack_o} = r_cmd;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq with a simple byte-controller responder.
// All stimulus and sampling happen on the falling clock edge.
module tb_i2c_xfer_seq;

   localparam logic [4:0] C_STWR = 5'b10010;
   localparam logic [4:0] C_WR   = 5'b00010;
   localparam logic [4:0] C_WRSP = 5'b01010;
   localparam logic [4:0] C_RD   = 5'b00100;
   localparam logic [4:0] C_RDSP = 5'b01101;
   localparam logic [4:0] C_SP   = 5'b01000;

   logic        clk_i;
   logic        rst_i;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic [1:0]  req_rnw_i;
   logic [13:0] req_dev_i;
   logic [15:0] req_reg_i;
   logic [5:0]  req_len_i;
   logic [63:0] req_wdata_i;
   logic [1:0]  rsp_valid_o;
   logic [1:0]  rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        busy_o;
   logic        start_o;
   logic        stop_o;
   logic        read_o;
   logic        write_o;
   logic        ack_o;
   logic [7:0]  dat_o;
   logic        cmd_ack_i;
   logic        ack_i;
   logic [7:0]  dat_i;
   logic        al_i;

   int n_chk;
   int n_pass;

   logic [4:0]  w_cb;
   logic [51:0] w_all;
   assign w_cb  = {start_o, stop_o, read_o, write_o, ack_o};
   assign w_all = {req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
                   busy_o, w_cb, dat_o};

   i2c_xfer_seq #(.NREQ(2), .MAXLEN(4)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_rnw_i  (req_rnw_i),
      .req_dev_i  (req_dev_i),
      .req_reg_i  (req_reg_i),
      .req_len_i  (req_len_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_err_o  (rsp_err_o),
      .rsp_rdata_o(rsp_rdata_o),
      .busy_o     (busy_o),
      .start_o    (start_o),
      .stop_o     (stop_o),
      .read_o     (read_o),
      .write_o    (write_o),
      .ack_o      (ack_o),
      .dat_o      (dat_o),
      .cmd_ack_i  (cmd_ack_i),
      .ack_i      (ack_i),
      .dat_i      (dat_i),
      .al_i       (al_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic req(input int r, input logic rnw, input logic [6:0] dev,
                      input logic [7:0] rg, input logic [2:0] len,
                      input logic [31:0] wd, input string tag);
      req_rnw_i[r]          = rnw;
      req_dev_i[7*r +: 7]   = dev;
      req_reg_i[8*r +: 8]   = rg;
      req_len_i[3*r +: 3]   = len;
      req_wdata_i[32*r +: 32] = wd;
      req_valid_i[r]        = 1'b1;
      @(negedge clk_i);
      chk({tag, "_ready"}, 64'(req_ready_o), 64'(2'b01 << r));
      chk({tag, "_busy"}, 64'(busy_o), 64'd1);
      req_valid_i = '0;
      req_rnw_i   = ~req_rnw_i;
      req_dev_i   = ~req_dev_i;
      req_reg_i   = ~req_reg_i;
      req_len_i   = ~req_len_i;
      req_wdata_i = ~req_wdata_i;
   endtask

   task automatic do_cmd(input string tag, input logic [4:0] eb,
                         input logic cd, input logic [7:0] ed,
                         input logic nk, input logic al,
                         input logic [7:0] rd);
      int t;
      t = 0;
      while (w_cb == 5'b0 && t < 40) begin
         @(negedge clk_i);
         t++;
      end
      chk(tag, 64'(w_cb), 64'(eb));
      if (cd) chk({tag, "_dat"}, 64'(dat_o), 64'(ed));
      @(negedge clk_i);
      chk({tag, "_hold"}, 64'(w_cb), 64'(eb));
      cmd_ack_i = 1'b1;
      al_i      = al;
      ack_i     = nk;
      dat_i     = rd;
      @(negedge clk_i);
      cmd_ack_i = 1'b0;
      al_i      = 1'b0;
      ack_i     = 1'b0;
      dat_i     = 8'h00;
      chk({tag, "_gap"}, 64'(w_cb), 64'd0);
   endtask

   task automatic chk_rsp(input string tag, input logic [1:0] ev,
                          input logic [1:0] ee, input logic [31:0] ed);
      chk({tag, "_rv"}, 64'(rsp_valid_o), 64'(ev));
      chk({tag, "_err"}, 64'(rsp_err_o), 64'(ee));
      chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(ed));
      chk({tag, "_busyrsp"}, 64'(busy_o), 64'd1);
      @(negedge clk_i);
      chk({tag, "_idle"}, 64'({busy_o, rsp_valid_o}), 64'd0);
   endtask

   initial begin
      logic saw;
      int   t;
      n_chk       = 0;
      n_pass      = 0;
      rst_i       = 1'b1;
      req_valid_i = '0;
      req_rnw_i   = '0;
      req_dev_i   = '0;
      req_reg_i   = '0;
      req_len_i   = '0;
      req_wdata_i = '0;
      cmd_ack_i   = 1'b0;
      ack_i       = 1'b0;
      dat_i       = 8'h00;
      al_i        = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("reset_out", 64'(w_all), 64'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      req(0, 1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, "wr");
      do_cmd("wr_dev", C_STWR, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00);
      do_cmd("wr_reg", C_WR,   1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
      do_cmd("wr_d0",  C_WR,   1'b1, 8'hEF, 1'b0, 1'b0, 8'h00);
      do_cmd("wr_d1",  C_WRSP, 1'b1, 8'hBE, 1'b0, 1'b0, 8'h00);
      chk_rsp("wr", 2'b01, 2'b00, 32'h0);

      req(1, 1'b1, 7'h68, 8'h75, 3'd3, 32'h0, "rd");
      do_cmd("rd_dev",  C_STWR, 1'b1, 8'hD0, 1'b0, 1'b0, 8'h00);
      do_cmd("rd_reg",  C_WR,   1'b1, 8'h75, 1'b0, 1'b0, 8'h00);
      do_cmd("rd_rdev", C_STWR, 1'b1, 8'hD1, 1'b0, 1'b0, 8'h00);
      do_cmd("rd_b0",   C_RD,   1'b0, 8'h00, 1'b0, 1'b0, 8'h11);
      do_cmd("rd_b1",   C_RD,   1'b0, 8'h00, 1'b0, 1'b0, 8'h22);
      do_cmd("rd_b2",   C_RDSP, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33);
      chk_rsp("rd", 2'b10, 2'b00, 32'h00332211);

      req(0, 1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, "nk");
      do_cmd("nk_dev",  C_STWR, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00);
      do_cmd("nk_reg",  C_WR,   1'b1, 8'h10, 1'b1, 1'b0, 8'h00);
      do_cmd("nk_stop", C_SP,   1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk_rsp("nk", 2'b01, 2'b01, 32'h0);

      req(1, 1'b0, 7'h22, 8'h33, 3'd2, 32'h00005566, "al");
      do_cmd("al_dev", C_STWR, 1'b1, 8'h44, 1'b0, 1'b0, 8'h00);
      do_cmd("al_reg", C_WR,   1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
      do_cmd("al_d0",  C_WR,   1'b1, 8'h66, 1'b0, 1'b0, 8'h00);
      do_cmd("al_d1",  C_WRSP, 1'b1, 8'h55, 1'b0, 1'b1, 8'h00);
      chk_rsp("al", 2'b10, 2'b10, 32'h0);
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk_i);
         saw = saw | (w_cb != 5'b0);
      end
      chk("al_nostop", 64'(saw), 64'd0);

      req_len_i   = {3'd5, 3'd0};
      req_valid_i = 2'b11;
      saw         = 1'b0;
      for (int g = 0; g < 4; g++) begin
         t = 0;
         while (req_ready_o == 2'b00 && t < 20) begin
            @(negedge clk_i);
            saw = saw | start_o;
            t++;
         end
         chk($sformatf("fair_g%0d", g), 64'(req_ready_o),
             64'((g % 2 == 1) ? 2'b10 : 2'b01));
         @(negedge clk_i);
         saw = saw | start_o;
         chk($sformatf("fair_rv%0d", g), 64'(rsp_valid_o),
             64'((g % 2 == 1) ? 2'b10 : 2'b01));
         chk($sformatf("fair_err%0d", g), 64'(rsp_err_o), 64'h3);
         if (g == 3) req_valid_i = 2'b00;
      end
      @(negedge clk_i);
      chk("fair_nostart", 64'(saw), 64'd0);
      chk("fair_idle", 64'(busy_o), 64'd0);

      req(1, 1'b1, 7'h68, 8'h75, 3'd2, 32'h0, "rs");
      do_cmd("rs_dev",  C_STWR, 1'b1, 8'hD0, 1'b0, 1'b0, 8'h00);
      do_cmd("rs_reg",  C_WR,   1'b1, 8'h75, 1'b0, 1'b0, 8'h00);
      do_cmd("rs_rdev", C_STWR, 1'b1, 8'hD1, 1'b0, 1'b0, 8'h00);
      t = 0;
      while (w_cb == 5'b0 && t < 20) begin
         @(negedge clk_i);
         t++;
      end
      chk("rs_rdat", 64'(w_cb), 64'(C_RD));
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rs_out", 64'(w_all), 64'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      req(0, 1'b0, 7'h11, 8'h22, 3'd1, 32'h00000033, "pr");
      do_cmd("pr_dev", C_STWR, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
      do_cmd("pr_reg", C_WR,   1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
      do_cmd("pr_d0",  C_WRSP, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
      chk_rsp("pr", 2'b01, 2'b00, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
